// File: rtl/cam_stream_gen.sv
// Replays a stored Y frame from a frame-buffer read port as a camera stream (vsync/href/data).
// Optional STREAM_TEST_PATTERN_EN adds a generated (col ^ line) pattern source with identical timing.
module cam_stream_gen #(
    parameter int W      = 8,
    parameter int AW     = 16,
    parameter int VS_LEN = 16,
    parameter int VB_LEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [15:0]   pic_width,
    input  logic [15:0]   pic_height,
    input  logic [15:0]   h_blank,
    input  logic          test_pattern,
    output logic [AW-1:0] aa_frame_buf,
    output logic          cena_frame_buf,
    input  logic [W-1:0]  qa_frame_buf,
    output logic          cam_vsync_o,
    output logic          cam_href_o,
    output logic [W-1:0]  cam_data_o,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        LINE,
        HBLANK,
        FLUSH
    } state_t;

    state_t        state, state_next;
    logic [15:0]   cnt;
    logic [15:0]   line_cnt;
    logic [15:0]   width_r, height_r, hblank_r;
    logic [15:0]   limit;
    logic          last;
    logic [AW-1:0] addr;
    logic          rd, rd_d1;
    logic          pat_sel;
    logic [W-1:0]  data_src;
    logic          accept;

    assign accept = (state == IDLE) && start;

`ifdef STREAM_TEST_PATTERN_EN
    logic         tp_r;
    logic [W-1:0] pat_d1;

    // Pattern value is staged one cycle so it lines up with where qa would have arrived.
    always_ff @(posedge clk) begin
        if (rst) begin
            tp_r   <= 1'b0;
            pat_d1 <= '0;
        end else begin
            if (accept) tp_r <= test_pattern;
            if (rd)     pat_d1 <= W'(cnt ^ line_cnt);
        end
    end

    assign pat_sel  = tp_r;
    assign data_src = tp_r ? pat_d1 : qa_frame_buf;
`else
    logic unused_test_pattern;
    assign unused_test_pattern = test_pattern;
    assign pat_sel  = 1'b0;
    assign data_src = qa_frame_buf;
`endif

    always_comb begin
        limit = 16'd1;
        case (state)
            VSYNC:   limit = 16'(VS_LEN);
            VBACK:   limit = 16'(VB_LEN);
            LINE:    limit = width_r;
            HBLANK:  limit = (hblank_r == 16'd0) ? 16'd1 : hblank_r;
            FLUSH:   limit = 16'd2;
            default: limit = 16'd1;
        endcase
    end

    assign last = (cnt == limit - 16'd1);

    always_comb begin
        state_next = state;
        done       = 1'b0;
        case (state)
            IDLE:   if (start) state_next = VSYNC;
            VSYNC:  if (last) state_next = VBACK;
            VBACK: begin
                if (last)
                    state_next = (width_r == 16'd0 || height_r == 16'd0) ? FLUSH : LINE;
            end
            LINE:   if (last) state_next = HBLANK;
            HBLANK: if (last) state_next = (line_cnt + 16'd1 < height_r) ? LINE : FLUSH;
            FLUSH: begin
                if (last) begin
                    state_next = IDLE;
                    done       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy           = (state != IDLE);
    assign cam_vsync_o    = (state == VSYNC);
    assign rd             = (state == LINE);
    assign cena_frame_buf = !(rd && !pat_sel);
    assign aa_frame_buf   = addr;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            line_cnt <= '0;
            addr     <= '0;
            width_r  <= '0;
            height_r <= '0;
            hblank_r <= '0;
        end else begin
            cnt <= (state_next != state || state == IDLE) ? '0 : cnt + 16'd1;
            if (accept) begin
                width_r  <= pic_width;
                height_r <= pic_height;
                hblank_r <= h_blank;
                addr     <= '0;
                line_cnt <= '0;
            end else begin
                if (rd) addr <= addr + AW'(1);
                if (state == HBLANK && last) line_cnt <= line_cnt + 16'd1;
            end
        end
    end

    // Two-stage href: read issue -> qa valid -> registered data, so href and pixel coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_d1      <= 1'b0;
            cam_href_o <= 1'b0;
            cam_data_o <= '0;
        end else begin
            rd_d1      <= rd;
            cam_href_o <= rd_d1;
            if (rd_d1) cam_data_o <= data_src;
        end
    end

endmodule
